datamem_arbiter: RTL
====================

# datamem_arbiter

Two-requester controller sitting in front of the single-port `data_memory` array, which is synchronous-read and word-write only. It arbitrates round-robin between port 0 (core load/store unit) and port 1 (debug/DMA). It sequences each granted access into memory cycles, and turns sub-word stores into a read-modify-write pair so requesters get byte-enable semantics.

## Interface
- `ADDR_W`, 12, word address width; matches the memory's `data_mem_addr_depth`.
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`.
- `clk_70_mhz`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pN_req`  in  1  port N request (N=0,1); hold with fields stable until `pN_gnt`.
- `pN_we`  in  1  1 = store, 0 = load.
- `pN_addr`  in  ADDR_W  word address.
- `pN_wdata`  in  DATA_W  store data.
- `pN_be`  in  DATA_W/8  store byte enables; ignored for loads.
- `pN_gnt`  out  1  one-cycle accept pulse (combinational, IDLE only).
- `pN_rvalid`  out  1  one-cycle load-data-valid pulse.
- `pN_wack`  out  1  one-cycle store-complete pulse.
- `rdata`  out  DATA_W  load data; valid only with `pN_rvalid`.
- `busy`  out  1  FSM not in IDLE.
- `mem_addr`  out  ADDR_W  to memory address.
- `mem_wdata`  out  DATA_W  to memory write data.
- `mem_we`  out  1  to memory write enable.
- `mem_rdata`  in  DATA_W  from memory registered read output.

## Operation
- FSM states: IDLE, READ, RESP, WRITE, RMW_WR. Reset state is IDLE.
- Reset values: all outputs 0; latched request registers 0; round-robin pointer selects port 0.
- IDLE: if any `pN_req` is high, select a port:
  - Only one requesting: that port wins.
  - Both requesting: the port not granted last wins; port 0 wins the first tie after reset.
- On selection, assert `pN_gnt` that cycle and latch we/addr/wdata/be/port at the edge. Update the pointer.
- Next state from IDLE:
  - Load goes to READ.
  - Store with be = all-ones goes to WRITE.
  - Store with partial be goes to READ, flagged as RMW.
  - Store with be = 0: no memory access; pulse `pN_wack` in the same cycle as `gnt`; stay in IDLE.
- READ: drive `mem_addr` = latched addr, `mem_we`=0. Memory captures the word at the end of the cycle. Next state is RESP (load) or RMW_WR (RMW).
- RESP: `rdata` = `mem_rdata` (combinational pass-through); pulse `pN_rvalid` to the owning port; go to IDLE.
- WRITE: drive `mem_we`=1, `mem_wdata` = latched wdata; pulse `pN_wack`; go to IDLE.
- RMW_WR: drive `mem_we`=1. For each byte k, `mem_wdata` byte k = latched wdata byte k if be[k], else `mem_rdata` byte k. Pulse `pN_wack`; go to IDLE.
- Requests seen outside IDLE are not granted; `pN_gnt`=0. Requesters keep `req` asserted.
- `mem_we` is 1 only in WRITE and RMW_WR. In IDLE, `mem_addr`/`mem_wdata` hold their last values.
- `rdata` is 0 outside RESP.

## Timing
- Cycle 0 = cycle with `gnt`.
- Load: READ at cycle 1, `rvalid`+`rdata` at cycle 2, IDLE at cycle 3. Next grant earliest at cycle 3.
- Full store: WRITE/`wack` at cycle 1; memory updated at end of cycle 1; next grant earliest at cycle 2.
- Partial store: READ at cycle 1, RMW_WR/`wack` at cycle 2; next grant earliest at cycle 3.
- Zero-be store: `wack` at cycle 0; next grant earliest at cycle 1.
- A load issued after a store by either port returns the stored data; the memory is never accessed concurrently.
- Reset asserted mid-operation immediately forces IDLE and all outputs to 0, including `mem_we`. The aborted access produces no `rvalid`/`wack`. A store whose WRITE/RMW_WR cycle is cut by reset is not guaranteed written.
- Reset deassertion while `pN_req` is high: grant on the first clock edge after release, with port 0 priority.

## Test plan
- Port 0 full store addr 0x010 data 0xDEADBEEF be 0xF, then load 0x010 -> `p0_wack` cycle 1; load `p0_rvalid` 2 cycles after its gnt with `rdata`=0xDEADBEEF.
- Mem[0x020]=0x11223344; port 1 store be=0x6 data 0xAABBCCDD -> READ then RMW_WR; `p1_wack` at cycle 2; later load returns 0x11BBCC44.
- Both ports request loads continuously from reset -> grants alternate p0, p1, p0, p1, each 3 cycles apart; no port granted twice in a row.
- Store be=0x0 to 0x030 holding 0x5A5A5A5A -> `wack` same cycle as `gnt`; `mem_we` never high; mem[0x030] unchanged.
- `rst_n` pulsed low during RMW READ cycle -> `busy`, `mem_we`, `wack` all 0 immediately; target word unchanged; FSM idle after release.
- Port 1 requests while port 0 load in READ -> `p1_gnt` stays 0 until IDLE at cycle 3, then granted.

Source files
------------

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: round-robin two-port front end for a single-port sync-read word memory,
// expanding partial-byte stores into a read-modify-write pair.
module datamem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk_70_mhz,
  input  logic                rst_n,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_be,
  output logic                p0_gnt,
  output logic                p0_rvalid,
  output logic                p0_wack,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_be,
  output logic                p1_gnt,
  output logic                p1_rvalid,
  output logic                p1_wack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int BE_W = DATA_W / 8;
  typedef enum logic [2:0] {IDLE, READ, RESP, WRITE, RMW_WR} state_t;
  state_t            r_state;
  logic              r_ptr, r_port, r_rmw;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata, r_mem_wdata, w_merge, w_wdata;
  logic [ADDR_W-1:0] r_mem_addr, w_addr;
  logic [BE_W-1:0]   w_be;
  logic              w_idle, w_go, w_sel, w_we, w_zero, w_full, w_zwack, w_wr, w_resp;
  // grant is gated by rst_n so every output reads 0 while reset is held
  assign w_idle  = rst_n && r_state == IDLE;
  assign w_sel   = (p0_req && p1_req) ? r_ptr : p1_req;
  assign w_go    = w_idle && (p0_req || p1_req);
  assign w_we    = w_sel ? p1_we : p0_we;
  assign w_addr  = w_sel ? p1_addr : p0_addr;
  assign w_wdata = w_sel ? p1_wdata : p0_wdata;
  assign w_be    = w_sel ? p1_be : p0_be;
  assign w_zero  = ~|w_be;
  assign w_full  = &w_be;
  assign w_zwack = w_go && w_we && w_zero;
  assign w_wr    = r_state == WRITE || r_state == RMW_WR;
  assign w_resp  = r_state == RESP;
  always_comb begin
    w_merge = mem_rdata;
    for (int k = 0; k < BE_W; k++)
      if (r_be[k]) w_merge[8*k +: 8] = r_wdata[8*k +: 8];
  end
  assign p0_gnt    = w_go && !w_sel;
  assign p1_gnt    = w_go && w_sel;
  assign p0_wack   = (w_zwack && !w_sel) || (w_wr && !r_port);
  assign p1_wack   = (w_zwack && w_sel) || (w_wr && r_port);
  assign p0_rvalid = w_resp && !r_port;
  assign p1_rvalid = w_resp && r_port;
  assign rdata     = w_resp ? mem_rdata : '0;
  assign busy      = r_state != IDLE;
  assign mem_we    = w_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_state == RMW_WR ? w_merge : r_mem_wdata;
  always_ff @(posedge clk_70_mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_port      <= 1'b0;
      r_rmw       <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          r_ptr   <= !w_sel;
          r_port  <= w_sel;
          r_rmw   <= w_we;
          r_be    <= w_be;
          r_wdata <= w_wdata;
          if (!(w_we && w_zero)) r_mem_addr <= w_addr;
          if (w_we && w_full) begin
            r_mem_wdata <= w_wdata;
            r_state     <= WRITE;
          end else if (!(w_we && w_zero)) r_state <= READ;
        end
        READ:    r_state <= r_rmw ? RMW_WR : RESP;
        RMW_WR: begin
          r_mem_wdata <= w_merge;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
